flash_rd_arbiter: RTL and testbench

- Shares the single SPI-flash memory read port (spimemio-style valid/ready/addr/rdata) between two requesters:
  - port 0: CPU instruction/XIP fetch;
  - port 1: a secondary reader, e.g. bootloader copy engine or debug.
- Sequences one flash transaction at a time.
- Arbitration is round-robin, with a bounded sequential-burst lock that keeps continuous-read mode efficient on spimemio.
- Sits between the PicoSoC bus decode and spimemio inside the hx8kdemo top.

---
 rtl/flash_arb_defs_pkg.sv | 16 +
 rtl/flash_arb_pick.sv | 34 +++
 rtl/flash_rd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_flash_rd_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_defs_pkg.sv
// Shared definitions for the flash read arbiter: FSM encodings, abort data and port indices.
package flash_arb_defs;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  // Read data returned to a requester whose transaction was aborted by the timeout.
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/flash_arb_pick.sv
// Combinational winner selection: burst continuation for the current owner, otherwise
// round-robin on a tie, otherwise the single requesting port.
module flash_arb_pick
  import flash_arb_defs::*;
(
  input  logic m0_valid_i,
  input  logic m1_valid_i,
  input  logic owner_i,
  input  logic seq_hit_i,       // owner's address is last granted word + 1
  input  logic burst_lt_max_i,  // burst_cnt < BURST_MAX
  output logic grant_valid_o,
  output logic grant_idx_o,
  output logic burst_continue_o
);

  logic owner_valid;

  // Priority: burst continue, then alternate on a tie, then whichever port is requesting.
  always_comb begin
    owner_valid      = (owner_i == P0) ? m0_valid_i : m1_valid_i;
    burst_continue_o = owner_valid && seq_hit_i && burst_lt_max_i;
    grant_valid_o    = m0_valid_i || m1_valid_i;
    if (burst_continue_o) begin
      grant_idx_o = owner_i;
    end else if (m0_valid_i && m1_valid_i) begin
      grant_idx_o = ~owner_i;
    end else if (m0_valid_i) begin
      grant_idx_o = P0;
    end else begin
      grant_idx_o = P1;
    end
  end

endmodule

// File: rtl/flash_rd_arbiter.sv
// Two-port arbiter in front of the spimemio read port. One flash transaction at a time,
// round-robin with a bounded sequential-burst lock for continuous-read efficiency.
// Optional ISSUE timeout enabled by defining FLASH_RD_ARBITER_TIMEOUT_EN.
module flash_rd_arbiter
  import flash_arb_defs::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned BURST_MAX   = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              flash_valid,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_ready,
  input  logic [31:0]       flash_rdata,
  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned     WordW    = ADDR_W - 2;
  localparam logic [WordW-1:0] WordOne = WordW'(1);
  localparam logic [3:0]      BurstMax = 4'(BURST_MAX);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WordW-1:0] last_word_q, last_word_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic [31:0]      m0_rdata_q, m0_rdata_d;
  logic [31:0]      m1_rdata_q, m1_rdata_d;

  logic [WordW-1:0] owner_word, grant_word;
  logic             seq_hit, grant_valid, grant_idx, burst_continue;

`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
  localparam int unsigned    TmoW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoOne = TmoW'(1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_err_q, tmo_err_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // Byte-lane bits never reach the flash; the port is word-addressed.
  logic unused_lanes;
  assign unused_lanes = ^{m0_addr[1:0], m1_addr[1:0]};

  // Sequential means exactly one word past the last grant, wrapping at the top of flash.
  assign owner_word = (owner_q == P0) ? m0_addr[ADDR_W-1:2] : m1_addr[ADDR_W-1:2];
  assign seq_hit    = (owner_word == last_word_q + WordOne);
  assign grant_word = (grant_idx == P0) ? m0_addr[ADDR_W-1:2] : m1_addr[ADDR_W-1:2];

  flash_arb_pick u_pick (
    .m0_valid_i       (m0_valid),
    .m1_valid_i       (m1_valid),
    .owner_i          (owner_q),
    .seq_hit_i        (seq_hit),
    .burst_lt_max_i   (burst_cnt_q < BurstMax),
    .grant_valid_o    (grant_valid),
    .grant_idx_o      (grant_idx),
    .burst_continue_o (burst_continue)
  );

  // Next-state: grant in IDLE, wait for flash (or timeout) in ISSUE, one-cycle RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_word_d = last_word_q;
    burst_cnt_d = burst_cnt_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d     = grant_idx;
          last_word_d = grant_word;
          burst_cnt_d = burst_continue ? burst_cnt_q + 4'd1 : 4'd1;
          state_d     = StIssue;
`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
      StIssue: begin
        if (flash_ready) begin
          if (owner_q == P0) m0_rdata_d = flash_rdata;
          else               m1_rdata_d = flash_rdata;
          state_d = StResp;
        end
`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
        else if (tmo_cnt_q == TmoMax) begin
          if (owner_q == P0) m0_rdata_d = ERR_RDATA;
          else               m1_rdata_d = ERR_RDATA;
          burst_cnt_d = 4'd0;
          tmo_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoOne;
        end
`endif
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      owner_q     <= P1;
      last_word_q <= '0;
      burst_cnt_q <= 4'd0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_word_q <= last_word_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  assign flash_valid = (state_q == StIssue);
  assign flash_addr  = {last_word_q, 2'b00};
  assign m0_ready    = (state_q == StResp) && (owner_q == P0);
  assign m1_ready    = (state_q == StResp) && (owner_q == P1);
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign owner       = owner_q;
  assign busy        = (state_q == StIssue) || (state_q == StResp);
`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// Directed bench for flash_rd_arbiter: queue-driven requesters and a fixed-latency flash model,
// all advanced from one tick task sampled on the falling edge.
module tb_flash_rd_arbiter;

`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
  localparam int unsigned TmoCyc = 16;
`else
  localparam int unsigned TmoCyc = 1023;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [23:0] m0_addr = '0, m1_addr = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        flash_valid;
  logic [23:0] flash_addr;
  logic        flash_ready = 1'b0;
  logic [31:0] flash_rdata = '0;
  logic        owner, busy, timeout_err;

  flash_rd_arbiter #(
    .ADDR_W      (24),
    .BURST_MAX   (4),
    .TIMEOUT_CYC (TmoCyc)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0_valid    (m0_valid),
    .m0_addr     (m0_addr),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_addr     (m1_addr),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .flash_valid (flash_valid),
    .flash_addr  (flash_addr),
    .flash_ready (flash_ready),
    .flash_rdata (flash_rdata),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Requester queues and grant log.
  logic [23:0] q0[$], q1[$];
  bit          port_log[$];
  logic [31:0] data_log[$];
  int          cyc_log[$];

  // Flash model controls: respond on the flash_lat-th ISSUE cycle; 0 means never.
  int          flash_lat = 1;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;
  bit          force_fr = 1'b0;
  int          fv_cnt = 0;

  int cyc = 0;
  int first_fv_cyc = -1;
  logic [23:0] first_fv_addr = '0;
  int fr_cyc = -1;
  int tmo_seen = 0;
  int tmo_cyc = -1;
  int both_rdy = 0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (m0_ready && m1_ready) both_rdy++;
    if (m0_ready) begin
      port_log.push_back(1'b0); data_log.push_back(m0_rdata); cyc_log.push_back(cyc);
    end
    if (m1_ready) begin
      port_log.push_back(1'b1); data_log.push_back(m1_rdata); cyc_log.push_back(cyc);
    end
    if (timeout_err) begin
      tmo_seen++;
      tmo_cyc = cyc;
    end
    if (flash_valid && first_fv_cyc < 0) begin
      first_fv_cyc  = cyc;
      first_fv_addr = flash_addr;
    end
    // Requesters retire the head on ready and immediately present the next entry.
    if (m0_ready && q0.size() > 0) void'(q0.pop_front());
    if (m1_ready && q1.size() > 0) void'(q1.pop_front());
    m0_valid = (q0.size() > 0);
    if (m0_valid) m0_addr = q0[0];
    m1_valid = (q1.size() > 0);
    if (m1_valid) m1_addr = q1[0];
    // Flash model.
    flash_ready = 1'b0;
    if (flash_valid) begin
      fv_cnt++;
      if (fv_cnt == flash_lat) begin
        flash_ready = 1'b1;
        flash_rdata = use_fixed ? fixed_data : {8'hC3, flash_addr};
        fr_cyc      = cyc;
      end
    end else begin
      fv_cnt = 0;
    end
    if (force_fr) flash_ready = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    q0.delete();
    q1.delete();
    force_fr = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    port_log.delete();
    data_log.delete();
    cyc_log.delete();
    first_fv_cyc = -1;
    fr_cyc = -1;
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int k = 0;
    while (port_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (port_log.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (flash_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_flash_valid got %b want 0", flash_valid); end
    vectors++; if (flash_addr !== 24'h0) begin miscompares++;
      $display("FAIL reset_flash_addr got %h want 000000", flash_addr); end
    vectors++; if ({m0_ready, m1_ready} !== 2'b00) begin miscompares++;
      $display("FAIL reset_ready got %b want 00", {m0_ready, m1_ready}); end
    vectors++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin miscompares++;
      $display("FAIL reset_rdata got %h/%h want 0/0", m0_rdata, m1_rdata); end
    vectors++; if (owner !== 1'b1) begin miscompares++;
      $display("FAIL reset_owner got %b want 1", owner); end
    vectors++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin miscompares++;
      $display("FAIL reset_busy_tmo got %b/%b want 0/0", busy, timeout_err); end
  endtask

  task automatic test_single_read();
    bit ok;
    int req_cyc;
    do_reset();
    use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF; flash_lat = 5;
    q0.push_back(24'h10_0000);
    req_cyc = cyc + 1;
    run_until(1, 40, ok);
    repeat (4) tick();
    use_fixed = 1'b0;
    vectors++; if (!ok) begin miscompares++;
      $display("FAIL single_done got %0d readies want 1", port_log.size()); end
    else begin
      vectors++; if (first_fv_addr !== 24'h10_0000) begin miscompares++;
        $display("FAIL single_flash_addr got %h want 100000", first_fv_addr); end
      vectors++; if (first_fv_cyc !== req_cyc + 1) begin miscompares++;
        $display("FAIL single_fv_latency got %0d want %0d", first_fv_cyc, req_cyc + 1); end
      vectors++; if (port_log[0] !== 1'b0 || data_log[0] !== 32'hDEAD_BEEF) begin miscompares++;
        $display("FAIL single_m0_data got p%0d %h want p0 deadbeef", port_log[0], data_log[0]); end
      vectors++; if (cyc_log[0] !== fr_cyc + 1) begin miscompares++;
        $display("FAIL single_ready_after_fr got %0d want %0d", cyc_log[0], fr_cyc + 1); end
      vectors++; if (cyc_log[0] - req_cyc !== 6) begin miscompares++;
        $display("FAIL single_total_latency got %0d want 6", cyc_log[0] - req_cyc); end
      vectors++; if (port_log.size() !== 1 || m1_rdata !== 32'h0) begin miscompares++;
        $display("FAIL single_no_m1 got %0d readies m1_rdata %h want 1 0", port_log.size(),
                 m1_rdata); end
    end
  endtask

  task automatic test_tie_after_reset();
    bit ok;
    int req_cyc;
    do_reset();
    flash_lat = 1;
    q0.push_back(24'h00_0200);
    q1.push_back(24'h00_0300);
    req_cyc = cyc + 1;
    run_until(2, 40, ok);
    vectors++; if (!ok) begin miscompares++;
      $display("FAIL tie_done got %0d readies want 2", port_log.size()); end
    else begin
      vectors++; if ({port_log[0], port_log[1]} !== 2'b01) begin miscompares++;
        $display("FAIL tie_order got %b%b want 01", port_log[0], port_log[1]); end
      vectors++; if (data_log[0] !== 32'hC300_0200 || data_log[1] !== 32'hC300_0300) begin
        miscompares++;
        $display("FAIL tie_data got %h %h want c3000200 c3000300", data_log[0], data_log[1]); end
      // Request mid-IDLE cycle, ISSUE with immediate flash_ready, ready in RESP: 2 ticks later.
      vectors++; if (cyc_log[0] - req_cyc !== 2) begin miscompares++;
        $display("FAIL tie_min_latency got %0d want 2", cyc_log[0] - req_cyc); end
      vectors++; if (m0_rdata !== 32'hC300_0200) begin miscompares++;
        $display("FAIL tie_m0_rdata_kept got %h want c3000200", m0_rdata); end
    end
  endtask

  task automatic test_burst_lock();
    bit ok;
    bit          exp_p[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_d[6] = '{32'hC300_0000, 32'hC300_0004, 32'hC300_0008, 32'hC300_000C,
                              32'hC300_0800, 32'hC300_0010};
    do_reset();
    flash_lat = 2;
    for (int i = 0; i < 5; i++) q0.push_back(24'(i * 4));
    q1.push_back(24'h00_0800);
    run_until(6, 80, ok);
    vectors++; if (!ok) begin miscompares++;
      $display("FAIL burst_done got %0d readies want 6", port_log.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        vectors++; if (port_log[i] !== exp_p[i] || data_log[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL burst_grant%0d got p%0d %h want p%0d %h", i, port_log[i], data_log[i],
                   exp_p[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_non_sequential();
    bit ok;
    do_reset();
    flash_lat = 1;
    q0.push_back(24'h00_0000);
    q0.push_back(24'h00_0040);
    q1.push_back(24'h00_0900);
    run_until(3, 60, ok);
    vectors++; if (!ok) begin miscompares++;
      $display("FAIL nonseq_done got %0d readies want 3", port_log.size()); end
    else begin
      vectors++; if ({port_log[0], port_log[1], port_log[2]} !== 3'b010) begin miscompares++;
        $display("FAIL nonseq_order got %b%b%b want 010", port_log[0], port_log[1],
                 port_log[2]); end
      vectors++; if (data_log[2] !== 32'hC300_0040) begin miscompares++;
        $display("FAIL nonseq_third_data got %h want c3000040", data_log[2]); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    flash_lat = 1;
    q0.push_back(24'hFF_FFFC);
    q0.push_back(24'h00_0000);
    q1.push_back(24'h00_0A00);
    run_until(3, 60, ok);
    vectors++; if (!ok) begin miscompares++;
      $display("FAIL wrap_done got %0d readies want 3", port_log.size()); end
    else begin
      vectors++; if ({port_log[0], port_log[1], port_log[2]} !== 3'b001) begin miscompares++;
        $display("FAIL wrap_order got %b%b%b want 001", port_log[0], port_log[1],
                 port_log[2]); end
      vectors++; if (data_log[1] !== 32'hC300_0000) begin miscompares++;
        $display("FAIL wrap_data got %h want c3000000", data_log[1]); end
    end
  endtask

  task automatic test_stray_ready();
    int n0;
    n0 = port_log.size();
    force_fr = 1'b1;
    tick();
    force_fr = 1'b0;
    repeat (3) tick();
    vectors++; if (port_log.size() !== n0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL stray_ready got %0d readies busy %b want %0d 0", port_log.size(), busy,
               n0); end
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    int k = 0;
    do_reset();
    flash_lat = 0;
    q0.push_back(24'h00_0400);
    while (!flash_valid && k < 10) begin tick(); k++; end
    vectors++; if (flash_valid !== 1'b1) begin miscompares++;
      $display("FAIL rstmid_issue got flash_valid %b want 1", flash_valid); end
    resetn = 1'b0;
    tick();
    vectors++; if (flash_valid !== 1'b0 || owner !== 1'b1) begin miscompares++;
      $display("FAIL rstmid_drop got fv %b owner %b want 0 1", flash_valid, owner); end
    q0.delete();
    tick();
    resetn = 1'b1;
    vectors++; if (port_log.size() !== 0) begin miscompares++;
      $display("FAIL rstmid_no_ready got %0d readies want 0", port_log.size()); end
    flash_lat = 1;
    q0.push_back(24'h00_0500);
    q1.push_back(24'h00_0600);
    run_until(2, 40, ok);
    vectors++; if (!ok || port_log[0] !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_tie got %0d readies first p%0d want 2 p0", port_log.size(),
               ok ? port_log[0] : 1'b1); end
  endtask

`ifdef FLASH_RD_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    do_reset();
    flash_lat = 0;
    tmo_seen = 0;
    q1.push_back(24'h00_0700);
    run_until(1, 60, ok);
    vectors++; if (!ok) begin miscompares++;
      $display("FAIL tmo_done got %0d readies want 1", port_log.size()); end
    else begin
      vectors++; if (tmo_cyc - first_fv_cyc !== 17) begin miscompares++;
        $display("FAIL tmo_latency got %0d want 17", tmo_cyc - first_fv_cyc); end
      vectors++; if (port_log[0] !== 1'b1 || data_log[0] !== 32'hFFFF_FFFF ||
                     cyc_log[0] !== tmo_cyc) begin miscompares++;
        $display("FAIL tmo_resp got p%0d %h @%0d want p1 ffffffff @%0d", port_log[0],
                 data_log[0], cyc_log[0], tmo_cyc); end
      vectors++; if (flash_valid !== 1'b0) begin miscompares++;
        $display("FAIL tmo_fv_drop got %b want 0", flash_valid); end
    end
    force_fr = 1'b1;
    tick();
    force_fr = 1'b0;
    repeat (3) tick();
    vectors++; if (port_log.size() !== 1 || tmo_seen !== 1 || m1_rdata !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL tmo_late_ready got %0d readies %0d pulses %h want 1 1 ffffffff",
               port_log.size(), tmo_seen, m1_rdata); end
  endtask
`else
  task automatic test_timeout();
    vectors++; if (tmo_seen !== 0) begin miscompares++;
      $display("FAIL no_timeout_err got %0d pulses want 0", tmo_seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_tie_after_reset();
    test_burst_lock();
    test_non_sequential();
    test_wrap();
    test_stray_ready();
    test_reset_mid_issue();
    test_timeout();
    vectors++; if (both_rdy !== 0) begin miscompares++;
      $display("FAIL dual_ready got %0d cycles want 0", both_rdy); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
